// File: rtl/synaptic_core_rmw.sv
// synaptic_core_rmw: request-driven read-modify-write engine around the synaptic SRAM.
// Performs READ, SDSP plastic update, bistability refresh or masked programming of one packed word.
`default_nettype none
`timescale 1ns/1ps

module synaptic_core_rmw #(
  parameter  int N            = 256,
  parameter  int M            = 8,
  parameter  int WBITS        = 4,
  parameter  int SYN_PER_WORD = 8,
  localparam int WORD_W       = WBITS * SYN_PER_WORD,
  localparam int WPP          = N / SYN_PER_WORD,
  localparam int ADDR_W       = $clog2(N * WPP),
  localparam int NSLICE       = WORD_W / M,
  localparam int SLICE_W      = (NSLICE > 1) ? $clog2(NSLICE) : 1
) (
  input  logic                    CLK,
  input  logic                    RST_sync,
  input  logic                    REQ_VALID,
  output logic                    REQ_READY,
  input  logic [1:0]              REQ_OP,
  input  logic [ADDR_W-1:0]       REQ_ADDR,
  input  logic [SYN_PER_WORD-1:0] REQ_PRE_EN,
  input  logic [SLICE_W-1:0]      REQ_SLICE,
  input  logic [2*M-1:0]          REQ_PROG_DATA,
  input  logic                    SPI_UPDATE_UNMAPPED_SYN,
  input  logic [N-1:0]            SPI_SYN_SIGN,
  input  logic [N-1:0]            NEUR_V_UP,
  input  logic [N-1:0]            NEUR_V_DOWN,
  output logic                    RSP_VALID,
  output logic [WORD_W-1:0]       RSP_RDATA,
  output logic [WORD_W-1:0]       RSP_WDATA,
  output logic                    RSP_SYN_SIGN,
  output logic                    BUSY
);

  localparam int PRE_W = $clog2(N);
  localparam int SPW_W = $clog2(SYN_PER_WORD);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_MOD  = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [1:0] OP_READ = 2'd0;
  localparam logic [1:0] OP_SDSP = 2'd1;
  localparam logic [1:0] OP_BIST = 2'd2;
  localparam logic [1:0] OP_PROG = 2'd3;

  localparam logic [WBITS-2:0] WMAX = '1;
  localparam logic [WBITS-1:0] HALF = WBITS'(1) << (WBITS - 2);

  logic [1:0]              state;
  logic [1:0]              op;
  logic [ADDR_W-1:0]       addr;
  logic [SYN_PER_WORD-1:0] pre_en;
  logic [SLICE_W-1:0]      slice;
  logic [2*M-1:0]          prog_data;

  logic [WORD_W-1:0] mem [N*WPP];
  logic [WORD_W-1:0] rd_word;
  logic [WORD_W-1:0] new_word;
  wire  [WORD_W-1:0] syn_word;
  wire  [WORD_W-1:0] prog_word;
  logic [PRE_W-1:0]  pre;
  logic [PRE_W-1:0]  post_base;

  function automatic logic [WBITS-1:0] syn_update(
    input logic [1:0]       f_op,
    input logic             en,
    input logic             allow_unmapped,
    input logic             up,
    input logic             dn,
    input logic [WBITS-1:0] syn
  );
    logic             mp;
    logic [WBITS-2:0] w;
    mp = syn[WBITS-1];
    w  = syn[WBITS-2:0];
    if (f_op == OP_SDSP && en && (allow_unmapped || mp)) begin
      if (up && !dn && w != WMAX)
        w = w + 1'b1;
      else if (dn && !up && w != '0)
        w = w - 1'b1;
    end else if (f_op == OP_BIST && en) begin
      // Refresh drives each weight towards whichever rail it is closer to.
      if ({1'b0, w} >= HALF) begin
        if (w != WMAX) w = w + 1'b1;
      end else if (w != '0) begin
        w = w - 1'b1;
      end
    end
    return {mp, w};
  endfunction

  assign REQ_READY = (state == S_IDLE) & ~RST_sync;
  assign BUSY      = (state != S_IDLE);
  assign pre       = addr[ADDR_W-1 -: PRE_W];
  // Low address bits are the post group; shifted up they give the first post-neuron of the word.
  assign post_base = PRE_W'(addr) << SPW_W;

  for (genvar j = 0; j < SYN_PER_WORD; j++) begin : g_syn
    logic [PRE_W-1:0] post;
    assign post = post_base | PRE_W'(j);
    assign syn_word[j*WBITS +: WBITS] = syn_update(op, pre_en[j], SPI_UPDATE_UNMAPPED_SYN,
                                                   NEUR_V_UP[post], NEUR_V_DOWN[post],
                                                   rd_word[j*WBITS +: WBITS]);
  end

  for (genvar s = 0; s < NSLICE; s++) begin : g_slice
    assign prog_word[s*M +: M] = (slice == SLICE_W'(s))
        ? ((prog_data[M-1:0] & ~prog_data[2*M-1:M]) | (rd_word[s*M +: M] & prog_data[2*M-1:M]))
        : rd_word[s*M +: M];
  end

  always_comb begin
    new_word = rd_word;
    case (op)
      OP_PROG: new_word = prog_word;
      OP_SDSP,
      OP_BIST: new_word = syn_word;
      default: new_word = rd_word;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST_sync) begin
      state        <= S_IDLE;
      op           <= OP_READ;
      addr         <= '0;
      pre_en       <= '0;
      slice        <= '0;
      prog_data    <= '0;
      RSP_VALID    <= 1'b0;
      RSP_RDATA    <= '0;
      RSP_WDATA    <= '0;
      RSP_SYN_SIGN <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (REQ_VALID) begin
            op        <= REQ_OP;
            addr      <= REQ_ADDR;
            pre_en    <= REQ_PRE_EN;
            slice     <= REQ_SLICE;
            prog_data <= REQ_PROG_DATA;
            state     <= S_RD;
          end
        end
        S_RD: state <= S_MOD;
        S_MOD: begin
          state        <= S_RESP;
          RSP_VALID    <= 1'b1;
          RSP_RDATA    <= rd_word;
          RSP_WDATA    <= new_word;
          RSP_SYN_SIGN <= SPI_SYN_SIGN[pre];
        end
        default: begin
          RSP_VALID <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

  // Synaptic SRAM: no reset so contents survive RST_sync; a reset during MOD suppresses the write.
  always_ff @(posedge CLK) begin
    if (state == S_RD)
      rd_word <= mem[addr];
    if (state == S_MOD && op != OP_READ && !RST_sync)
      mem[addr] <= new_word;
  end

endmodule

`default_nettype wire

// File: tb/tb_synaptic_core_rmw.sv
// tb_synaptic_core_rmw: randomized self-checking bench for synaptic_core_rmw against a word-level model.
`default_nettype none
`timescale 1ns/1ps

module tb_synaptic_core_rmw;

  localparam int N = 256;
  localparam int WBITS = 4;
  localparam int WMAX = 7;
  localparam int HALF = 4;

  logic        CLK = 1'b0;
  logic        RST_sync = 1'b1;
  logic        REQ_VALID = 1'b0;
  logic        REQ_READY;
  logic [1:0]  REQ_OP = '0;
  logic [12:0] REQ_ADDR = '0;
  logic [7:0]  REQ_PRE_EN = '0;
  logic [1:0]  REQ_SLICE = '0;
  logic [15:0] REQ_PROG_DATA = '0;
  logic        SPI_UPDATE_UNMAPPED_SYN = 1'b0;
  logic [N-1:0] SPI_SYN_SIGN = '0;
  logic [N-1:0] NEUR_V_UP = '0;
  logic [N-1:0] NEUR_V_DOWN = '0;
  logic        RSP_VALID;
  logic [31:0] RSP_RDATA;
  logic [31:0] RSP_WDATA;
  logic        RSP_SYN_SIGN;
  logic        BUSY;

  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] mdl [int];

  synaptic_core_rmw dut (
    .CLK(CLK), .RST_sync(RST_sync),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_OP(REQ_OP), .REQ_ADDR(REQ_ADDR),
    .REQ_PRE_EN(REQ_PRE_EN), .REQ_SLICE(REQ_SLICE), .REQ_PROG_DATA(REQ_PROG_DATA),
    .SPI_UPDATE_UNMAPPED_SYN(SPI_UPDATE_UNMAPPED_SYN), .SPI_SYN_SIGN(SPI_SYN_SIGN),
    .NEUR_V_UP(NEUR_V_UP), .NEUR_V_DOWN(NEUR_V_DOWN),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_WDATA(RSP_WDATA),
    .RSP_SYN_SIGN(RSP_SYN_SIGN), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model (word/synapse level) ----------------
  function automatic logic [31:0] ref_sdsp(input logic [31:0] old, input logic [7:0] en,
                                           input logic unm, input logic [12:0] a,
                                           input logic [N-1:0] up, input logic [N-1:0] dn);
    logic [31:0] r;
    int w, mp, p;
    r = old;
    for (int j = 0; j < 8; j++) begin
      w  = int'(old[4*j +: 3]);
      mp = int'(old[4*j+3]);
      p  = int'(a % 32) * 8 + j;
      if (en[j] && (unm || mp == 1)) begin
        if (up[p] && !dn[p]) w = (w + 1 > WMAX) ? WMAX : w + 1;
        else if (dn[p] && !up[p]) w = (w == 0) ? 0 : w - 1;
      end
      r[4*j +: 4] = 4'(mp * 8 + w);
    end
    return r;
  endfunction

  function automatic logic [31:0] ref_bist(input logic [31:0] old, input logic [7:0] en);
    logic [31:0] r;
    int w;
    r = old;
    for (int j = 0; j < 8; j++) begin
      w = int'(old[4*j +: 3]);
      if (en[j]) w = (w >= HALF) ? ((w + 1 > WMAX) ? WMAX : w + 1) : ((w == 0) ? 0 : w - 1);
      r[4*j +: 3] = 3'(w);
    end
    return r;
  endfunction

  function automatic logic [31:0] ref_prog(input logic [31:0] old, input int sl,
                                           input logic [7:0] data, input logic [7:0] mask);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 8; b++)
      if (!mask[b]) r[sl*8 + b] = data[b];
    return r;
  endfunction

  // ---------------- driver ----------------
  task automatic do_req(input logic [1:0] op, input logic [12:0] a, input logic [7:0] en,
                        input logic [1:0] sl, input logic [15:0] pd,
                        output logic [31:0] rd, output logic [31:0] wd, output logic sg,
                        output int lat, output logic [4:0] rdy);
    @(negedge CLK);
    REQ_OP = op; REQ_ADDR = a; REQ_PRE_EN = en; REQ_SLICE = sl; REQ_PROG_DATA = pd;
    REQ_VALID = 1'b1;
    @(posedge CLK);
    #1;
    REQ_VALID = 1'b0;
    REQ_OP = 2'($urandom); REQ_ADDR = 13'($urandom); REQ_PRE_EN = 8'($urandom);
    REQ_SLICE = 2'($urandom); REQ_PROG_DATA = 16'($urandom);
    lat = 0; rdy = '0; rd = '0; wd = '0; sg = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge CLK);
      rdy[k-1] = REQ_READY;
      if (RSP_VALID) begin
        lat = (lat == 0) ? k : 99;
        rd = RSP_RDATA; wd = RSP_WDATA; sg = RSP_SYN_SIGN;
      end
    end
  endtask

  task automatic init_word(input logic [12:0] a, input logic [31:0] w);
    logic [31:0] rd, wd;
    logic sg;
    int lat;
    logic [4:0] rdy;
    for (int s = 0; s < 4; s++)
      do_req(2'd3, a, 8'h00, 2'(s), {8'h00, w[s*8 +: 8]}, rd, wd, sg, lat, rdy);
    mdl[int'(a)] = w;
  endtask

  task automatic rand_vec(output logic [N-1:0] v);
    for (int i = 0; i < N / 32; i++) v[i*32 +: 32] = $urandom;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    RST_sync = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    n_cmp++;
    if ({RSP_VALID, BUSY, RSP_SYN_SIGN, REQ_READY} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 0000", {RSP_VALID, BUSY, RSP_SYN_SIGN, REQ_READY});
    end
    n_cmp++;
    if (RSP_RDATA !== 32'h0 || RSP_WDATA !== 32'h0) begin
      n_fail++; $display("FAIL reset_data: got %h/%h expected 0/0", RSP_RDATA, RSP_WDATA);
    end
    RST_sync = 1'b0;
    #1;
    n_cmp++;
    if (REQ_READY !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b expected 1", REQ_READY);
    end
  endtask

  task automatic test_prog_read;
    logic [31:0] rd, wd, exp;
    logic sg;
    int lat;
    logic [4:0] rdy;
    init_word(13'h0005, $urandom);
    exp = ref_prog(mdl[5], 0, 8'h3A, 8'h00);
    do_req(2'd3, 13'h0005, 8'h00, 2'd0, 16'h003A, rd, wd, sg, lat, rdy);
    n_cmp++;
    if (lat != 3 || rdy !== 5'b11000) begin
      n_fail++; $display("FAIL prog_timing: lat %0d ready %b expected 3 11000", lat, rdy);
    end
    n_cmp++;
    if (rd !== mdl[5] || wd !== exp) begin
      n_fail++; $display("FAIL prog_word: got %h/%h expected %h/%h", rd, wd, mdl[5], exp);
    end
    mdl[5] = exp;
    do_req(2'd0, 13'h0005, 8'hFF, 2'd1, 16'h1234, rd, wd, sg, lat, rdy);
    n_cmp++;
    if (lat != 3 || rdy !== 5'b11000) begin
      n_fail++; $display("FAIL read_timing: lat %0d ready %b expected 3 11000", lat, rdy);
    end
    n_cmp++;
    if (rd[7:0] !== 8'h3A || rd !== mdl[5] || wd !== mdl[5]) begin
      n_fail++; $display("FAIL read_word: got %h/%h expected %h (low byte 3a)", rd, wd, mdl[5]);
    end
  endtask

  task automatic test_sdsp_sat;
    logic [31:0] rd, wd, exp;
    logic sg;
    int lat;
    logic [4:0] rdy;
    init_word(13'h0000, 32'h8F8F8F9F);
    NEUR_V_UP = '0; NEUR_V_DOWN = '0;
    NEUR_V_UP[0] = 1'b1; NEUR_V_DOWN[1] = 1'b1;
    SPI_UPDATE_UNMAPPED_SYN = 1'b0;
    for (int it = 0; it < 2; it++) begin
      exp = ref_sdsp(mdl[0], 8'hFF, 1'b0, 13'h0000, NEUR_V_UP, NEUR_V_DOWN);
      do_req(2'd1, 13'h0000, 8'hFF, 2'd0, 16'h0, rd, wd, sg, lat, rdy);
      n_cmp++;
      if (rd !== mdl[0] || wd !== exp || wd[7:0] !== 8'h8F) begin
        n_fail++; $display("FAIL sdsp_sat%0d: got %h/%h expected %h/%h", it, rd, wd, mdl[0], exp);
      end
      mdl[0] = exp;
    end
  endtask

  task automatic test_unmapped;
    logic [31:0] rd, wd;
    logic sg;
    int lat;
    logic [4:0] rdy;
    logic [12:0] a;
    a = {8'd20, 5'd2};
    init_word(a, 32'h33333333);
    NEUR_V_UP = '0; NEUR_V_DOWN = '0;
    NEUR_V_UP[23:16] = 8'hFF;
    SPI_UPDATE_UNMAPPED_SYN = 1'b0;
    do_req(2'd1, a, 8'hFF, 2'd0, 16'h0, rd, wd, sg, lat, rdy);
    n_cmp++;
    if (wd !== 32'h33333333) begin
      n_fail++; $display("FAIL unmapped_off: got %h expected 33333333", wd);
    end
    SPI_UPDATE_UNMAPPED_SYN = 1'b1;
    do_req(2'd1, a, 8'hFF, 2'd0, 16'h0, rd, wd, sg, lat, rdy);
    n_cmp++;
    if (rd !== 32'h33333333 || wd !== 32'h44444444) begin
      n_fail++; $display("FAIL unmapped_on: got %h/%h expected 33333333/44444444", rd, wd);
    end
    mdl[int'(a)] = 32'h44444444;
  endtask

  task automatic test_bist;
    logic [31:0] rd, wd, exp;
    logic sg;
    int lat;
    logic [4:0] rdy;
    logic [7:0] en;
    logic [12:0] a;
    a = {8'd3, 5'd7};
    init_word(a, 32'hC3B44343);
    do_req(2'd2, a, 8'hFF, 2'd0, 16'h0, rd, wd, sg, lat, rdy);
    n_cmp++;
    if (wd !== 32'hD2A55252) begin
      n_fail++; $display("FAIL bist_all: got %h expected d2a55252", wd);
    end
    mdl[int'(a)] = 32'hD2A55252;
    do_req(2'd2, a, 8'h00, 2'd0, 16'h0, rd, wd, sg, lat, rdy);
    n_cmp++;
    if (rd !== mdl[int'(a)] || wd !== mdl[int'(a)]) begin
      n_fail++; $display("FAIL bist_none: got %h/%h expected %h", rd, wd, mdl[int'(a)]);
    end
    for (int it = 0; it < 4; it++) begin
      en = 8'($urandom);
      exp = ref_bist(mdl[int'(a)], en);
      do_req(2'd2, a, en, 2'd0, 16'h0, rd, wd, sg, lat, rdy);
      n_cmp++;
      if (wd !== exp) begin
        n_fail++; $display("FAIL bist_rand%0d: got %h expected %h", it, wd, exp);
      end
      mdl[int'(a)] = exp;
    end
  endtask

  task automatic test_prog_slice2;
    logic [31:0] rd, wd;
    logic sg;
    int lat;
    logic [4:0] rdy;
    logic [12:0] a;
    a = {8'h7F, 5'd3};
    init_word(a, 32'h12345678);
    rand_vec(SPI_SYN_SIGN);
    SPI_SYN_SIGN[8'h7F] = 1'b1;
    do_req(2'd3, a, 8'h00, 2'd2, {8'hF0, 8'hFF}, rd, wd, sg, lat, rdy);
    n_cmp++;
    if (rd !== 32'h12345678 || wd !== 32'h123F5678 || sg !== 1'b1) begin
      n_fail++; $display("FAIL prog_slice2: got %h/%h sign %b expected 12345678/123f5678 sign 1", rd, wd, sg);
    end
    mdl[int'(a)] = 32'h123F5678;
    SPI_SYN_SIGN[8'h7F] = 1'b0;
    do_req(2'd0, a, 8'h00, 2'd0, 16'h0, rd, wd, sg, lat, rdy);
    n_cmp++;
    if (rd !== 32'h123F5678 || sg !== 1'b0) begin
      n_fail++; $display("FAIL sign_read: got %h sign %b expected 123f5678 sign 0", rd, sg);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd, wd, exp, old;
    logic sg;
    int lat;
    logic [4:0] rdy;
    logic [12:0] pool [2];
    logic [12:0] a;
    logic [1:0] op, sl;
    logic [7:0] en;
    logic [15:0] pd;
    pool[0] = 13'($urandom_range(256, 4095));
    pool[1] = 13'($urandom_range(4096, 8191));
    init_word(pool[0], $urandom);
    init_word(pool[1], $urandom);
    for (int it = 0; it < 12; it++) begin
      a = pool[$urandom_range(0, 1)];
      op = 2'($urandom); en = 8'($urandom); sl = 2'($urandom); pd = 16'($urandom);
      SPI_UPDATE_UNMAPPED_SYN = 1'($urandom);
      rand_vec(NEUR_V_UP); rand_vec(NEUR_V_DOWN); rand_vec(SPI_SYN_SIGN);
      old = mdl[int'(a)];
      case (op)
        2'd0: exp = old;
        2'd1: exp = ref_sdsp(old, en, SPI_UPDATE_UNMAPPED_SYN, a, NEUR_V_UP, NEUR_V_DOWN);
        2'd2: exp = ref_bist(old, en);
        default: exp = ref_prog(old, int'(sl), pd[7:0], pd[15:8]);
      endcase
      do_req(op, a, en, sl, pd, rd, wd, sg, lat, rdy);
      n_cmp++;
      if (lat != 3 || rd !== old || wd !== exp || sg !== SPI_SYN_SIGN[a[12:5]]) begin
        n_fail++; $display("FAIL random%0d op%0d: lat %0d got %h/%h/%b expected %h/%h/%b",
                           it, op, lat, rd, wd, sg, old, exp, SPI_SYN_SIGN[a[12:5]]);
      end
      mdl[int'(a)] = exp;
    end
  endtask

  task automatic test_reset_abort;
    logic [31:0] rd, wd;
    logic sg;
    int lat, pulses;
    logic [4:0] rdy;
    init_word(13'h0040, 32'h11111111);
    NEUR_V_UP = '1; NEUR_V_DOWN = '0;
    SPI_UPDATE_UNMAPPED_SYN = 1'b1;
    @(negedge CLK);
    REQ_OP = 2'd1; REQ_ADDR = 13'h0040; REQ_PRE_EN = 8'hFF; REQ_VALID = 1'b1;
    @(posedge CLK);
    #1 REQ_VALID = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST_sync = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    n_cmp++;
    if (RSP_VALID !== 1'b0 || BUSY !== 1'b0) begin
      n_fail++; $display("FAIL abort_flags: valid %b busy %b expected 0 0", RSP_VALID, BUSY);
    end
    RST_sync = 1'b0;
    #1;
    n_cmp++;
    if (REQ_READY !== 1'b1) begin
      n_fail++; $display("FAIL abort_ready: got %b expected 1", REQ_READY);
    end
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      if (RSP_VALID) pulses++;
    end
    n_cmp++;
    if (pulses != 0) begin
      n_fail++; $display("FAIL abort_pulse: got %0d pulses expected 0", pulses);
    end
    do_req(2'd0, 13'h0040, 8'h00, 2'd0, 16'h0, rd, wd, sg, lat, rdy);
    n_cmp++;
    if (lat != 3 || rd !== 32'h11111111) begin
      n_fail++; $display("FAIL abort_mem: lat %0d got %h expected 3 11111111", lat, rd);
    end
  endtask

  initial begin
    test_reset();
    test_prog_read();
    test_sdsp_sat();
    test_unmapped();
    test_bist();
    test_prog_slice2();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/synaptic_core_rmw.md
Name: synaptic_core_rmw

Overview:
Parametrised next-generation synaptic core: a request-driven read-modify-write engine around an internal synchronous synaptic SRAM. Each accepted request targets one memory word of SYN_PER_WORD packed synapses and performs a read, an SDSP plastic update, a bistability refresh, or a masked SPI programming write. It sits between the controller (request/response handshake) and the neuron core (V_UP/V_DOWN vectors). Weight width, synapses per word and neuron count are generic; serialised FSM sequencing replaces the old combinational control.

Parameters:
N, 256, neuron count (power of 2); pre- and post-neuron index range 0..N-1
M, 8, SPI programming slice width in bits
WBITS, 4, bits per synapse: MSB = mapping bit, WBITS-1 LSBs = unsigned weight
SYN_PER_WORD, 8, synapses per memory word (power of 2, divides N)
Derived: WORD_W=WBITS*SYN_PER_WORD; WPP=N/SYN_PER_WORD (words per pre-neuron); ADDR_W=clog2(N*WPP); NSLICE=WORD_W/M; WMAX=2^(WBITS-1)-1

Ports:
CLK  in  1  clock, all logic on rising edge
RST_sync  in  1  synchronous, active-high reset
REQ_VALID  in  1  request valid
REQ_READY  out  1  core accepts a request this cycle
REQ_OP  in  2  00 READ, 01 SDSP, 10 BIST_REF, 11 PROG
REQ_ADDR  in  ADDR_W  word address {pre[clog2(N)-1:0], post_group[clog2(WPP)-1:0]}
REQ_PRE_EN  in  SYN_PER_WORD  per-synapse update enable (SDSP/BIST_REF)
REQ_SLICE  in  max(1,clog2(NSLICE))  M-bit slice selected for PROG
REQ_PROG_DATA  in  2*M  {mask[M-1:0], data[M-1:0]}; mask bit 1 = keep old bit
SPI_UPDATE_UNMAPPED_SYN  in  1  allow SDSP on synapses with mapping bit 0
SPI_SYN_SIGN  in  N  per-pre-neuron sign (1 = inhibitory)
NEUR_V_UP  in  N  post-neuron potentiation flags
NEUR_V_DOWN  in  N  post-neuron depression flags
RSP_VALID  out  1  one-cycle response pulse
RSP_RDATA  out  WORD_W  word as read before modification
RSP_WDATA  out  WORD_W  word as written (equals RSP_RDATA for READ)
RSP_SYN_SIGN  out  1  SPI_SYN_SIGN[pre] of the completed request
BUSY  out  1  high in any state except IDLE

Behaviour:
- FSM: IDLE -> RD -> MOD -> RESP -> IDLE. REQ_READY = (state==IDLE) & ~RST_sync; no other state accepts.
- Handshake on edge where REQ_VALID&REQ_READY: capture OP, ADDR, PRE_EN, SLICE, PROG_DATA; go RD. REQ_* ignored otherwise.
- RD: memory read of captured ADDR issued (CS=1, WE=0). MOD: read word valid; new word computed; written at end of MOD if OP!=READ. RESP: RSP_VALID=1 for one cycle, RSP_* registered; then IDLE.
- Latency: handshake edge t -> RSP_VALID high cycle t+3; next acceptance at t+4. Max throughput 1 request / 4 cycles.
- Synapse j (bits [j*WBITS +: WBITS]) maps to post-neuron p = post_group*SYN_PER_WORD + j. NEUR_V_UP/DOWN sampled live in MOD.
- SDSP, per j: enabled iff PRE_EN[j] & (SPI_UPDATE_UNMAPPED_SYN | map bit). V_UP&~V_DOWN: w+1 saturating at WMAX; V_DOWN&~V_UP: w-1 saturating at 0; both/neither: unchanged. Mapping bit never altered.
- BIST_REF, per j with PRE_EN[j] (mapping bit ignored): w >= 2^(WBITS-2) -> w+1 sat WMAX; else w-1 sat 0.
- PROG: slice s = bits [s*M +: M] becomes (data & ~mask) | (old & mask); other slices unchanged. REQ_SLICE >= NSLICE: no bits change, write still performed.
- RSP_SYN_SIGN = SPI_SYN_SIGN[ADDR[ADDR_W-1 -: clog2(N)]] sampled in MOD.
- Back-to-back requests to the same address observe the previous write (serialised, no hazard).
- Reset: state->IDLE; RSP_VALID, BUSY, RSP_RDATA, RSP_WDATA, RSP_SYN_SIGN -> 0. Reset in RD/MOD aborts: no memory write that cycle, no RSP_VALID. Memory contents are not cleared by reset.

Test Plan:
- PROG addr 0x0005, slice 0, data 0x3A, mask 0x00; then READ 0x0005 -> RSP_RDATA[7:0]=0x3A, RSP_VALID exactly 3 cycles after each handshake, REQ_READY low for 3 cycles.
- Word 0x0000 = 0x8F8F8F8F (map=1, w=7 / map=1,w=7...); SDSP, PRE_EN=0xFF, NEUR_V_UP[0]=1 -> synapse 0 stays 7 (saturation); set synapse 1 = 0x9 (w=1), V_DOWN[1]=1 twice -> w=0 then stays 0.
- Map bit 0, w=3, V_UP=1: SPI_UPDATE_UNMAPPED_SYN=0 -> unchanged 0x3; =1 -> 0x4.
- BIST_REF on word with w=4 and w=3, PRE_EN=all -> 5 and 2; PRE_EN=0 -> RSP_WDATA==RSP_RDATA.
- PROG slice 2, data 0xFF, mask 0xF0 over old 0x12345678 -> 0x123F5678; RSP_SYN_SIGN matches SPI_SYN_SIGN[pre] for pre=0x7F.
- Assert RST_sync during MOD of an SDSP request -> no RSP_VALID, subsequent READ returns original word; REQ_READY=1 first cycle after reset release.
